// File: rtl/seq_detect_scheduler.sv
// Shares one serial 11101 detector among four requesters with round-robin arbitration.
// Define SEQ_OVERLAP_EN for overlapping detection; undefined gives non-overlapping detection.
module seq_detect_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] din,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        done,
  output logic [2:0]  match_cnt,
  output logic [1:0]  result_id
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned W_ID   = 2;
  localparam int unsigned W_WORD = 16;
  localparam int unsigned W_CNT  = 3;
  localparam int unsigned W_BIT  = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
  typedef enum logic [2:0] {DET_A, DET_B, DET_C, DET_D, DET_E, DET_F} det_t;

  ctrl_t              state_q, state_d;
  det_t               det_q, det_d;
  logic [W_WORD-1:0]  shift_q, shift_d;
  logic [W_BIT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic [W_ID-1:0]    last_q, last_d;
  logic [W_ID-1:0]    cur_q, cur_d;
  logic [N_REQ-1:0]   grant_d;
  logic               busy_d;
  logic               done_d;
  logic [W_CNT-1:0]   match_d;
  logic [W_ID-1:0]    result_d;

  logic [W_ID-1:0]    win_c;
  logic               bit_c;
  logic               hit_c;
  logic [W_CNT-1:0]   cnt_inc_c;

  // First requesting index after the last winner, wrapping modulo four.
  function automatic logic [W_ID-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [W_ID-1:0] last);
    logic [W_ID-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = last + W_ID'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic det_t det_next(input det_t s, input logic b);
    case (s)
      DET_A:   det_next = b ? DET_B : DET_A;
      DET_B:   det_next = b ? DET_C : DET_A;
      DET_C:   det_next = b ? DET_D : DET_A;
      DET_D:   det_next = b ? DET_D : DET_E;
      DET_E:   det_next = b ? DET_F : DET_A;
`ifdef SEQ_OVERLAP_EN
      DET_F:   det_next = b ? DET_C : DET_A;
`else
      DET_F:   det_next = b ? DET_B : DET_A;
`endif
      default: det_next = DET_A;
    endcase
  endfunction

  assign win_c     = rr_pick(req, last_q);
  assign bit_c     = shift_q[W_WORD-1];
  assign hit_c     = (det_q == DET_E) && bit_c;
  assign cnt_inc_c = (hit_c && (cnt_q != {W_CNT{1'b1}})) ? cnt_q + W_CNT'(1) : cnt_q;

  // Controller next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    cur_d     = cur_q;
    grant_d   = grant;
    busy_d    = busy;
    done_d    = 1'b0;
    match_d   = '0;
    result_d  = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (|req) begin
          shift_d   = W_WORD'(din >> {win_c, 4'b0000});
          bit_cnt_d = '0;
          cnt_d     = '0;
          det_d     = DET_A;
          last_d    = win_c;
          cur_d     = win_c;
          grant_d   = N_REQ'(1) << win_c;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        det_d     = det_next(det_q, bit_c);
        cnt_d     = cnt_inc_c;
        bit_cnt_d = bit_cnt_q + W_BIT'(1);
        if (bit_cnt_q == {W_BIT{1'b1}}) begin
          state_d  = DONE;
          done_d   = 1'b1;
          match_d  = cnt_inc_c;
          result_d = cur_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      det_q     <= DET_A;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      last_q    <= W_ID'(N_REQ - 1);
      cur_q     <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      result_id <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      grant     <= grant_d;
      busy      <= busy_d;
      done      <= done_d;
      match_cnt <= match_d;
      result_id <= result_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Randomized scoreboard bench for seq_detect_scheduler; honours SEQ_OVERLAP_EN like the design.
module tb_seq_detect_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [63:0] din   = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [2:0]  match_cnt;
  logic [1:0]  result_id;

  seq_detect_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .din(din),
    .grant(grant), .busy(busy), .done(done),
    .match_cnt(match_cnt), .result_id(result_id)
  );

  always #5 clock = ~clock;

  typedef struct { int id; int cnt; } res_t;
  res_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: cycles left in the current job, last and current winner.
  int cool = 0;
  int last = 3;
  int cur  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Matches of 11101 in a 16-bit word scanned MSB first.
  function automatic int count_matches(input logic [15:0] w);
    int n = 0;
    int i = 0;
    while (i <= 11) begin
      if (((w >> (11 - i)) & 16'h001F) == 16'h001D) begin
        n++;
`ifdef SEQ_OVERLAP_EN
        i += 1;
`else
        i += 5;
`endif
      end else begin
        i += 1;
      end
    end
    return (n > 7) ? 7 : n;
  endfunction

  function automatic logic [15:0] gen_word();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'hEEE8;
      2:       return 16'h1D1D ^ 16'($urandom_range(0, 255));
      default: return 16'hFFFF ^ (16'h0001 << $urandom_range(0, 15));
    endcase
  endfunction

  // Behavioural model: a job occupies 17 cycles after its capture edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cool = 0;
      last = 3;
      cur  = 0;
      exp_q.delete();
    end else if (cool == 0) begin
      if (req != 4'b0000) begin
        res_t r;
        int idx = 0;
        for (int k = 4; k >= 1; k--) begin
          if (req[(last + k) % 4]) idx = (last + k) % 4;
        end
        r.id  = idx;
        r.cnt = count_matches(din[idx*16 +: 16]);
        exp_q.push_back(r);
        last = idx;
        cur  = idx;
        cool = 17;
      end
    end else begin
      cool--;
    end
  end

  // Monitor: per-cycle grant/busy/done timing plus result popping on done.
  always @(negedge clock) begin
    logic [3:0] eg;
    res_t r;
    eg = (cool > 0) ? (4'b0001 << cur) : 4'b0000;
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(cool > 0));
    check("done", 32'(done), 32'(cool == 1));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'(0));
      end else begin
        r = exp_q.pop_front();
        check("result_id", 32'(result_id), 32'(r.id));
        check("match_cnt", 32'(match_cnt), 32'(r.cnt));
      end
    end
  end

  task automatic wait_idle();
    int budget = 100;
    while (cool != 0 && budget > 0) begin
      @(posedge clock); #2;
      budget--;
    end
    if (cool != 0) check("idle_timeout", 32'(cool), 32'(0));
  endtask

  task automatic set_words(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    din = {w3, w2, w1, w0};
  endtask

  // Present a request for exactly one idle cycle, then drop it.
  task automatic serve_pulse(input logic [3:0] r);
    wait_idle();
    req = r;
    @(posedge clock); #2;
    req = 4'b0000;
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_match_cnt"}, 32'(match_cnt), 32'(0));
    check({tag, "_result_id"}, 32'(result_id), 32'(0));
  endtask

  initial begin
    #1;
    check_zero_outputs("reset");
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #2;

    set_words(16'hE800, 16'h0000, 16'h0000, 16'h0000);
    serve_pulse(4'b0001);
    set_words(16'hEEE8, 16'h0000, 16'h0000, 16'h0000);
    serve_pulse(4'b0001);

    // All requesters held: rotation 0,1,2,3,0 from a fresh reset.
    wait_idle();
    do_reset();
    set_words(16'hE800, 16'hEEE8, 16'h3A74, 16'hFFFF);
    req = 4'b1111;
    repeat (85) begin @(posedge clock); #2; end
    req = 4'b0000;

    // Reset during SHIFT cycle 8 discards the job.
    set_words(16'hE800, 16'h0000, 16'h0000, 16'h0000);
    serve_pulse(4'b0001);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(posedge clock); #3;
    reset = 1'b0;
    set_words(16'h0000, 16'h0000, 16'hEEE8, 16'h0000);
    serve_pulse(4'b0100);

    // Single-cycle pulse, then a request raised mid-job waits for IDLE.
    set_words(16'hE800, 16'h0000, 16'h0000, 16'h0000);
    serve_pulse(4'b0010);
    repeat (5) begin @(posedge clock); #2; end
    req = 4'b0001;
    repeat (40) begin @(posedge clock); #2; end
    req = 4'b0000;

    for (int it = 0; it < 150; it++) begin
      set_words(gen_word(), gen_word(), gen_word(), gen_word());
      req = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 30)) begin @(posedge clock); #2; end
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
    end
    req = 4'b0000;
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 SHALL have port clock, input, 1, single system clock, rising-edge active.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port req, input, 4, level request per requester i (bit i).
REQ-004 SHALL have port din, input, 64, requester i word on din[16i+15:16i], sampled only at capture.
REQ-005 SHALL have port grant, output, 4, registered one-hot, requester being served.
REQ-006 SHALL have port busy, output, 1, registered, high while not IDLE.
REQ-007 SHALL have port done, output, 1, registered one-cycle result strobe.
REQ-008 SHALL have port match_cnt, output, 3, matches of 11101 in the served word, valid when done=1.
REQ-009 SHALL have port result_id, output, 2, index of the served requester, valid when done=1.

Function
REQ-010 SHALL share one serial 11101 detector among 4 requesters via a controller FSM with states IDLE, SHIFT, DONE.
REQ-011 IDLE: if req!=0, SHALL pick a winner round-robin (priority starts at last_grant+1 mod 4), load its 16-bit word into the shift register, clear bit counter, match counter and detector state to A, and go to SHIFT; else stay in IDLE.
REQ-012 req SHALL be sampled only in IDLE; req changes during SHIFT/DONE are ignored.
REQ-013 SHIFT: SHALL feed one bit per cycle, MSB first, for exactly 16 cycles, then go to DONE.
REQ-014 DONE: SHALL assert done, match_cnt and result_id for exactly one cycle, then return to IDLE and clear grant.
REQ-015 Latency: req seen in IDLE at cycle T -> grant/busy high from T+1 through T+17; done high in T+17; earliest next capture at T+18.
REQ-016 last_grant SHALL update to the winner at capture; it is unaffected by idle cycles.
REQ-017 Detector transitions (A idle, B "1", C "11", D "111", E "1110", F matched): A:1->B,0->A; B:1->C,0->A; C:1->D,0->A; D:1->D,0->E; E:1->F,0->A; F per REQ-023.
REQ-018 A match SHALL be counted on every E->F transition, including on the 16th bit.
REQ-019 match_cnt SHALL saturate at 7 (unreachable in 16 bits; overflow not required).
REQ-020 Detector state SHALL NOT carry across words.
REQ-021 A requester holding req after its done SHALL be re-eligible at lowest rotating priority.

Reset
REQ-022 On reset assertion, regardless of clock, SHALL force IDLE, grant=0, busy=0, done=0, match_cnt=0, result_id=0, last_grant=3 (requester 0 first), detector=A; an in-flight word is discarded with no done.

Configuration
REQ-023 Macro SEQ_OVERLAP_EN: defined -> overlapping detection, F:1->C, F:0->A; undefined -> non-overlapping, F:1->B, F:0->A.

Verification
REQ-024 Reset, req=0001, din[15:0]=0xE800 -> grant=0001 at T+1, done at T+17, match_cnt=1, result_id=0.
REQ-025 req=0001, din[15:0]=0xEEE8 -> match_cnt=3 with SEQ_OVERLAP_EN, 2 without.
REQ-026 req=1111 held constantly, distinct words -> results in order ids 0,1,2,3,0, each done 18 cycles apart.
REQ-027 Reset asserted at SHIFT cycle 8 -> outputs zero immediately, no done; next req=0100 served with result_id=2.
REQ-028 req=0010 pulsed for the single IDLE cycle only, din=0x0000 -> served, match_cnt=0; req=0001 raised during SHIFT not served until next IDLE.
